// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin sharing of a single-port RAM between the CPU
// memory path and the program loader. CPU reads return data with a valid
// pulse, a stall output holds the control unit, and loader writes are counted.
module ram_port_arbiter #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          ldr_req,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  input  logic          ldr_lock,
  output logic          ldr_gnt,
  output logic [AW:0]   ldr_count,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_CPU = 2'd1,
    RD_WAIT = 2'd2,
    GNT_LDR = 2'd3
  } state_t;

  // Loader write count saturates at the number of RAM words.
  localparam logic [AW:0] CNT_MAX = {1'b1, {AW{1'b0}}};

  state_t        state;
  state_t        state_nx;
  logic          prio_cpu;
  logic          prio_cpu_nx;
  logic          cpu_elig;
  logic          ldr_elig;
  logic [AW-1:0] ram_addr_nx;
  logic [DW-1:0] ram_wdata_nx;
  logic          ram_we_nx;
  logic [AW:0]   ldr_count_nx;

  // Load mode masks the CPU out of arbitration (in-flight accesses still finish).
  assign ldr_elig = ldr_req;
  assign cpu_elig = cpu_req & ~ldr_lock;

  // State register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state: arbitrate in IDLE, reads take an extra cycle for RAM latency.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (ldr_elig && (!cpu_elig || !prio_cpu)) begin
          state_nx = GNT_LDR;
        end else if (cpu_elig) begin
          state_nx = GNT_CPU;
        end
      end
      GNT_CPU: state_nx = ram_we ? IDLE : RD_WAIT;
      RD_WAIT: state_nx = IDLE;
      GNT_LDR: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output/datapath next values: capture the winner's access and flip priority.
  always_comb begin
    ram_addr_nx  = ram_addr;
    ram_wdata_nx = ram_wdata;
    ram_we_nx    = 1'b0;
    prio_cpu_nx  = prio_cpu;
    ldr_count_nx = ldr_count;
    if (state == IDLE && state_nx == GNT_CPU) begin
      ram_addr_nx  = cpu_addr;
      ram_wdata_nx = cpu_wdata;
      ram_we_nx    = cpu_we;
      prio_cpu_nx  = 1'b0;
    end else if (state == IDLE && state_nx == GNT_LDR) begin
      ram_addr_nx  = ldr_addr;
      ram_wdata_nx = ldr_wdata;
      ram_we_nx    = 1'b1;
      prio_cpu_nx  = 1'b1;
      if (ldr_count != CNT_MAX) begin
        ldr_count_nx = ldr_count + (AW+1)'(1);
      end
    end
  end

  // Registered outputs, RAM port and priority bit.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      prio_cpu   <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_we     <= 1'b0;
      ldr_count  <= '0;
      cpu_gnt    <= 1'b0;
      ldr_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
    end else begin
      prio_cpu   <= prio_cpu_nx;
      ram_addr   <= ram_addr_nx;
      ram_wdata  <= ram_wdata_nx;
      ram_we     <= ram_we_nx;
      ldr_count  <= ldr_count_nx;
      cpu_gnt    <= (state_nx == GNT_CPU);
      ldr_gnt    <= (state_nx == GNT_LDR);
      cpu_rvalid <= (state_nx == RD_WAIT);
    end
  end

  // RAM read data is already one cycle late, so it is passed through while valid.
  assign cpu_rdata = cpu_rvalid ? ram_rdata : '0;

  // Stall the ring counter until the CPU access has been completed.
  assign cpu_stall = cpu_req & ~(cpu_rvalid | (cpu_gnt & cpu_we));

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: randomized and directed stimulus against a
// transaction-level schedule model of the arbiter plus a RAM array model.
module tb_ram_port_arbiter;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          ldr_req = 1'b0;
  logic [AW-1:0] ldr_addr = '0;
  logic [DW-1:0] ldr_wdata = '0;
  logic          ldr_lock = 1'b0;
  logic          ldr_gnt;
  logic [AW:0]   ldr_count;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;

  ram_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .clr(clr),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_lock(ldr_lock),
    .ldr_gnt(ldr_gnt), .ldr_count(ldr_count),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM driven by the arbiter.
  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  logic [DW-1:0] mem_model [16];
  int            kk = 0;
  int            free_at = 0;
  int            pend_at = -1;
  logic [DW-1:0] pend_data;
  bit            turn_ldr = 1'b1;
  int            e_cnt = 0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0;
  bit            e_cg, e_lg, e_rv, e_we;
  logic [DW-1:0] e_rd;
  int            p_ldr = 0;
  int            p_cpu = 0;
  bit            lock_rand = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, kk);
  endtask

  task automatic model_reset();
    free_at  = 0;
    pend_at  = -1;
    turn_ldr = 1'b1;
    e_cnt    = 0;
    e_addr   = '0;
    e_wdata  = '0;
    e_cg = 0; e_lg = 0; e_rv = 0; e_we = 0; e_rd = '0;
  endtask

  // Advance the model by one clock edge using the inputs the DUT just sampled.
  task automatic model_edge();
    bit le, ce;
    kk++;
    e_cg = 0; e_lg = 0; e_rv = 0; e_we = 0; e_rd = '0;
    if (pend_at == kk) begin
      e_rv = 1;
      e_rd = pend_data;
    end
    if (kk >= free_at) begin
      le = ldr_req;
      ce = cpu_req && !ldr_lock;
      if (le && (!ce || turn_ldr)) begin
        e_lg = 1; e_we = 1; e_addr = ldr_addr; e_wdata = ldr_wdata;
        mem_model[ldr_addr] = ldr_wdata;
        if (e_cnt < 16) e_cnt++;
        turn_ldr = 0;
        free_at  = kk + 2;
      end else if (ce) begin
        e_cg = 1; e_we = cpu_we; e_addr = cpu_addr; e_wdata = cpu_wdata;
        turn_ldr = 1;
        if (cpu_we) begin
          mem_model[cpu_addr] = cpu_wdata;
          free_at = kk + 2;
        end else begin
          pend_at   = kk + 1;
          pend_data = mem_model[cpu_addr];
          free_at   = kk + 3;
        end
      end
    end
  endtask

  task automatic check_all();
    check("cpu_gnt", 32'(cpu_gnt), 32'(e_cg));
    check("ldr_gnt", 32'(ldr_gnt), 32'(e_lg));
    check("cpu_rvalid", 32'(cpu_rvalid), 32'(e_rv));
    check("cpu_rdata", 32'(cpu_rdata), 32'(e_rd));
    check("ram_we", 32'(ram_we), 32'(e_we));
    check("ram_addr", 32'(ram_addr), 32'(e_addr));
    check("ram_wdata", 32'(ram_wdata), 32'(e_wdata));
    check("ldr_count", 32'(ldr_count), 32'(e_cnt));
    check("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !(e_rv || (e_cg && cpu_we))));
    check("excl", 32'(int'(cpu_gnt) + int'(ldr_gnt) + int'(cpu_rvalid) <= 1), 32'(1));
  endtask

  // Requesters drop after service and raise new random requests.
  task automatic drive();
    if (ldr_req && e_lg) ldr_req = 0;
    if (!ldr_req && $urandom_range(99) < p_ldr) begin
      ldr_req = 1; ldr_addr = AW'($urandom); ldr_wdata = DW'($urandom);
    end
    if (cpu_req && (e_rv || (e_cg && cpu_we))) cpu_req = 0;
    if (!cpu_req && $urandom_range(99) < p_cpu) begin
      cpu_req = 1; cpu_we = 1'($urandom); cpu_addr = AW'($urandom); cpu_wdata = DW'($urandom);
    end
    if (lock_rand && $urandom_range(99) < 3) ldr_lock = ~ldr_lock;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    model_edge();
    check_all();
    drive();
  endtask

  // Assert clr asynchronously, check immediate reset values, release a cycle later.
  task automatic do_reset();
    clr = 1;
    #1;
    model_reset();
    check("rst_cpu_gnt", 32'(cpu_gnt), 0);
    check("rst_ldr_gnt", 32'(ldr_gnt), 0);
    check("rst_rvalid", 32'(cpu_rvalid), 0);
    check("rst_rdata", 32'(cpu_rdata), 0);
    check("rst_ram_we", 32'(ram_we), 0);
    check("rst_ram_addr", 32'(ram_addr), 0);
    check("rst_ram_wdata", 32'(ram_wdata), 0);
    check("rst_count", 32'(ldr_count), 0);
    @(negedge clk);
    clr = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i]       = DW'($urandom);
      mem_model[i] = mem[i];
    end
    @(negedge clk);
    do_reset();

    // Single loader write 0xA5 to addr 3.
    ldr_req = 1; ldr_addr = 4'd3; ldr_wdata = 8'hA5;
    step();
    check("dir_ldr_cnt", 32'(ldr_count), 1);
    step();
    // Loader writes 0x5C to addr 7, CPU reads it back.
    ldr_req = 1; ldr_addr = 4'd7; ldr_wdata = 8'h5C;
    step();
    step();
    cpu_req = 1; cpu_we = 0; cpu_addr = 4'd7; cpu_wdata = 8'h00;
    step();
    check("dir_rd_gnt", 32'(cpu_gnt), 1);
    step();
    check("dir_rd_data", 32'(cpu_rdata), 32'h5C);
    step();
    // CPU write 0x0F to addr 2.
    cpu_req = 1; cpu_we = 1; cpu_addr = 4'd2; cpu_wdata = 8'h0F;
    step();
    check("dir_wr_we", 32'(ram_we), 1);
    step();

    // Load mode: CPU locked out while the loader writes 20 times.
    cpu_req = 1; cpu_we = 0; cpu_addr = 4'd2; ldr_lock = 1; p_ldr = 100;
    for (int i = 0; i < 40; i++) step();
    check("sat_count", 32'(ldr_count), 16);
    ldr_lock = 0; p_ldr = 0;
    for (int i = 0; i < 8; i++) step();

    // Both requesting continuously from reset: strict alternation.
    do_reset();
    p_ldr = 100; p_cpu = 100;
    for (int i = 0; i < 30; i++) step();
    p_ldr = 0; p_cpu = 0;
    for (int i = 0; i < 8; i++) step();
    ldr_req = 0; cpu_req = 0;
    step();

    // clr during RD_WAIT discards the read; loader has priority afterwards.
    cpu_req = 1; cpu_we = 0; cpu_addr = 4'd7;
    begin
      int n = 0;
      while (!e_cg && n < 10) begin step(); n++; end
      check("clr_wait_gnt", 32'(e_cg), 1);
    end
    step();
    check("clr_in_rdwait", 32'(cpu_rvalid), 1);
    cpu_req = 0;
    do_reset();
    for (int i = 0; i < 4; i++) step();
    ldr_req = 1; ldr_addr = 4'd9; ldr_wdata = 8'h33;
    cpu_req = 1; cpu_we = 0; cpu_addr = 4'd9;
    step();
    check("clr_prio_ldr", 32'(ldr_gnt), 1);
    for (int i = 0; i < 6; i++) step();

    // Random traffic with occasional load mode.
    p_ldr = 50; p_cpu = 50; lock_rand = 1;
    for (int i = 0; i < 600; i++) step();
    lock_rand = 0; ldr_lock = 0; p_ldr = 0; p_cpu = 0;
    for (int i = 0; i < 10; i++) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
